// File: rtl/shreg_fifo_ctrl.sv
// shreg_fifo_ctrl: valid/ready elastic buffer built on an addressable shift register plus output register.
// Optional empty-buffer bypass enabled by defining SHREG_FIFO_BYPASS_EN.
module shreg_fifo_ctrl #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         s_valid_i,
  output logic                         s_ready_o,
  input  logic [Width-1:0]             s_data_i,
  output logic                         m_valid_o,
  input  logic                         m_ready_i,
  output logic [Width-1:0]             m_data_o,
  output logic [$clog2(Depth+2)-1:0]   count_o
);
  localparam int CW = $clog2(Depth+1);
  localparam int OW = $clog2(Depth+2);
  localparam int AW = $clog2(Depth);
  logic [Width-1:0] mem [Depth];
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr;
  logic push, out_free, pop_srl, bypass, push_srl;
  always_comb begin
    s_ready_o = !rst_i && cnt != CW'(Depth);
    push = s_valid_i && s_ready_o;
    out_free = !m_valid_o || m_ready_i;
    pop_srl = cnt != '0 && out_free;
`ifdef SHREG_FIFO_BYPASS_EN
    bypass = push && cnt == '0 && out_free;
`else
    bypass = 1'b0;
`endif
    push_srl = push && !bypass;
    addr = cnt == '0 ? '0 : AW'(cnt - CW'(1));
    count_o = OW'(cnt) + OW'(m_valid_o);
  end
  // Storage is never reset; newest word enters at address 0, oldest sits at cnt-1.
  always_ff @(posedge clk_i) begin
    if (push_srl) begin
      mem[0] <= s_data_i;
      for (int i = 1; i < Depth; i++) mem[i] <= mem[i-1];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) cnt <= '0;
    else if (push_srl && !pop_srl) cnt <= cnt + CW'(1);
    else if (pop_srl && !push_srl) cnt <= cnt - CW'(1);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_valid_o <= 1'b0;
      m_data_o <= '0;
    end else if (flush_i) m_valid_o <= 1'b0;
    else if (pop_srl) begin
      m_valid_o <= 1'b1;
      m_data_o <= mem[addr];
    end else if (bypass) begin
      m_valid_o <= 1'b1;
      m_data_o <= s_data_i;
    end else if (m_ready_i) m_valid_o <= 1'b0;
  end
endmodule

// File: tb/tb_shreg_fifo_ctrl.sv
// tb_shreg_fifo_ctrl: randomized bench comparing the FIFO against a queue-based reference model.
module tb_shreg_fifo_ctrl;
  localparam int W = 8;
  localparam int D = 16;
  logic clk = 0;
  logic rst = 1, flush = 0, s_valid = 0, m_ready = 0;
  logic [W-1:0] s_data = '0;
  logic s_ready, m_valid;
  logic [W-1:0] m_data;
  logic [$clog2(D+2)-1:0] count;
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];
  logic last_pop;
  logic [W-1:0] last_got, last_exp;
  always #5 clk = ~clk;
  shreg_fifo_ctrl #(.Width(W), .Depth(D)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_data_i(s_data), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .count_o(count)
  );
  // Model: occupancy is simply the number of accepted-but-not-delivered words.
  task automatic tick();
    logic push, pop;
    push = s_valid && s_ready;
    pop = m_valid && m_ready;
    last_pop = pop;
    if (pop) begin
      last_got = m_data;
      last_exp = q.size() > 0 ? q[0] : 'x;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (push) q.push_back(s_data);
    if (flush || rst) q.delete();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", s_ready); end
    rst = 0;
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b want 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data got %h want 00", m_data); end
    checks++; if (count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
  endtask
  task automatic test_single();
    m_ready = 1; s_valid = 1; s_data = 8'hA5;
    tick();
    s_valid = 0;
`ifndef SHREG_FIFO_BYPASS_EN
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", m_valid); end
    tick();
`endif
    checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin errors++; $display("FAIL single_out got v=%0b d=%h want v=1 d=a5", m_valid, m_data); end
    tick();
    checks++; if (last_pop !== 1'b1 || last_got !== last_exp) begin errors++; $display("FAIL single_pop got %h want %h", last_got, last_exp); end
    checks++; if (count !== 0 || m_valid !== 1'b0) begin errors++; $display("FAIL single_empty got c=%0d v=%0b want 0 0", count, m_valid); end
  endtask
  task automatic test_fill();
    m_ready = 0;
    for (int i = 0; i <= D; i++) begin
      s_valid = 1; s_data = W'(i);
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fill_ready word %0d got 0 want 1", i); end
      tick();
    end
    s_data = 8'h99;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", s_ready); end
    checks++; if (count !== D + 1) begin errors++; $display("FAIL full_count got %0d want %0d", count, D + 1); end
    tick();
    s_valid = 0; m_ready = 1;
    for (int i = 0; i <= D; i++) begin
      checks++; if (m_valid !== 1'b1 || m_data !== W'(i)) begin errors++; $display("FAIL drain_order idx %0d got v=%0b d=%h want v=1 d=%h", i, m_valid, m_data, W'(i)); end
      tick();
    end
    checks++; if (count !== 0) begin errors++; $display("FAIL drain_count got %0d want 0", count); end
  endtask
  task automatic test_full_pop();
    m_ready = 0; s_valid = 1;
    for (int i = 0; i <= D; i++) begin s_data = W'($urandom); tick(); end
    checks++; if (count !== D + 1) begin errors++; $display("FAIL fp_count got %0d want %0d", count, D + 1); end
    m_ready = 1; s_data = 8'h5E;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fp_same_cycle got %0b want 0", s_ready); end
    tick();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fp_next_cycle got %0b want 1", s_ready); end
    checks++; if (count !== D) begin errors++; $display("FAIL fp_after got %0d want %0d", count, D); end
    s_valid = 0;
    for (int n = 0; n < 4 * D && q.size() > 0; n++) begin
      tick();
      if (last_pop) begin checks++; if (last_got !== last_exp) begin errors++; $display("FAIL fp_drain got %h want %h", last_got, last_exp); end end
    end
    tick();
    checks++; if (count !== 0 || q.size() != 0) begin errors++; $display("FAIL fp_empty got %0d want 0", count); end
  endtask
  task automatic test_stream();
    m_ready = 0; s_valid = 1;
    for (int i = 0; i < D / 2; i++) begin s_data = W'($urandom); tick(); end
    for (int n = 0; n < 400; n++) begin
      s_data = W'($urandom);
      m_ready = 1'($urandom);
      tick();
      if (last_pop) begin checks++; if (last_got !== last_exp) begin errors++; $display("FAIL stream_data got %h want %h", last_got, last_exp); end end
      checks++; if (count !== q.size() || count > D + 1) begin errors++; $display("FAIL stream_count got %0d want %0d", count, q.size()); end
    end
    s_valid = 0; m_ready = 1;
    for (int n = 0; n < 4 * D && q.size() > 0; n++) begin
      tick();
      if (last_pop) begin checks++; if (last_got !== last_exp) begin errors++; $display("FAIL stream_drain got %h want %h", last_got, last_exp); end end
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL stream_drain_timeout got %0d want 0", q.size()); end
  endtask
  task automatic test_flush(input bit use_rst);
    bit seen;
    m_ready = 0; s_valid = 1;
    for (int i = 0; i < 9; i++) begin s_data = W'($urandom); tick(); end
    checks++; if (count !== 9) begin errors++; $display("FAIL fl_pre_count got %0d want 9", count); end
    s_data = 8'h77;
    if (use_rst) rst = 1; else flush = 1;
    tick();
    if (use_rst) begin
      checks++; if (s_ready !== 1'b0 || m_data !== '0) begin errors++; $display("FAIL rst_mid got r=%0b d=%h want 0 00", s_ready, m_data); end
    end
    rst = 0; flush = 0; s_valid = 0;
    checks++; if (count !== 0 || m_valid !== 1'b0) begin errors++; $display("FAIL fl_clear got c=%0d v=%0b want 0 0", count, m_valid); end
    s_valid = 1; s_data = 8'h3C; m_ready = 1;
    tick();
    s_valid = 0;
    seen = 0;
    for (int n = 0; n < 5 && !seen; n++) begin
      if (m_valid) seen = 1;
      else tick();
    end
    checks++; if (!seen || m_data !== 8'h3C) begin errors++; $display("FAIL fl_first got v=%0b d=%h want v=1 d=3c", m_valid, m_data); end
    tick();
    checks++; if (count !== 0) begin errors++; $display("FAIL fl_end_count got %0d want 0", count); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_pop();
    test_stream();
    test_flush(0);
    test_flush(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
